// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache memory responder.
// Covers line/address widths, write-granularity codes and responder FSM states.
package cache_mem_pkg;

    localparam int unsigned LINE_W = 128;
    localparam int unsigned ADDR_W = 36;

    typedef enum logic [1:0] {
        WT_WORD  = 2'b00,
        WT_LINE  = 2'b01,
        WT_DWORD = 2'b10,
        WT_LINE2 = 2'b11
    } wtype_e;

    localparam logic [1:0] FLUSH_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FLUSH
    } state_e;

endpackage

// File: rtl/cache_resp_merge.sv
// Write-merge of incoming data into an existing line at word, dword or line granularity.
// Unwritten lanes pass through from the old line.
module cache_resp_merge
    import cache_mem_pkg::*;
(
    input  logic [LINE_W-1:0] old_line_i,
    input  logic [LINE_W-1:0] wr_data_i,
    input  logic [1:0]        w_type_i,
    input  logic [1:0]        lane_i,
    output logic [LINE_W-1:0] line_o
);

    always_comb begin
        line_o = old_line_i;
        case (w_type_i)
            WT_WORD:  line_o[32*lane_i +: 32]    = wr_data_i[32*lane_i +: 32];
            WT_DWORD: line_o[64*lane_i[1] +: 64] = wr_data_i[64*lane_i[1] +: 64];
            default:  line_o = wr_data_i;
        endcase
    end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder: latency-modelled read/write of a line-wide store,
// edge-triggered full-store clear, and request statistics.
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int unsigned IDX_W = 8,
    parameter int unsigned LAT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r,
    input  logic              w,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wr_data,
    input  logic [1:0]        w_type,
    input  logic [1:0]        flushtype,
    output logic              mem_stall,
    output logic [LINE_W-1:0] rd_data,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
    output logic              err
);

    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned CNT_W = (LAT > 2) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LAT > 0) ? LAT - 1 : 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  fidx_q, fidx_d;
    logic              flush_seen_q;
    logic              err_q, err_d;
    logic [31:0]       rd_cnt_q, wr_cnt_q;
    logic [LINE_W-1:0] store [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic [LINE_W-1:0] merged;
    logic              complete;
    logic              flush_we;
    logic              flush_trig;
    logic              unused_addr;

    assign idx         = addr[4 +: IDX_W];
    assign unused_addr = ^{addr[ADDR_W-1:4+IDX_W], addr[1:0]};
    assign rd_data     = store[idx];
    assign rd_count    = rd_cnt_q;
    assign wr_count    = wr_cnt_q;
    assign err         = err_q;
    assign flush_trig  = (flushtype == FLUSH_CLEAR) && !flush_seen_q;

    cache_resp_merge u_merge (
        .old_line_i (store[idx]),
        .wr_data_i  (wr_data),
        .w_type_i   (w_type),
        .lane_i     (addr[3:2]),
        .line_o     (merged)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fidx_d    = fidx_q;
        err_d     = err_q;
        mem_stall = 1'b0;
        complete  = 1'b0;
        flush_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_trig) begin
                    mem_stall = 1'b1;
                    fidx_d    = '0;
                    state_d   = FLUSH;
                end else if (r || w) begin
                    err_d = err_q | (r & w);
                    if (LAT == 0) begin
                        complete = 1'b1;
                    end else begin
                        mem_stall = 1'b1;
                        cnt_d     = CNT_LOAD;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            FLUSH: begin
                mem_stall = 1'b1;
                flush_we  = 1'b1;
                fidx_d    = fidx_q + IDX_W'(1);
                if (fidx_q == '1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A completing r&w request is a write; reads count only when w is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            fidx_q       <= '0;
            flush_seen_q <= 1'b0;
            err_q        <= 1'b0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fidx_q       <= fidx_d;
            flush_seen_q <= (flushtype == FLUSH_CLEAR);
            err_q        <= err_d;
            if (complete && !w) rd_cnt_q <= rd_cnt_q + 32'd1;
            if (complete && w)  wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (flush_we)            store[fidx_q] <= '0;
            else if (complete && w)  store[idx]    <= merged;
        end
    end

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Memory-side responder for the cache request interface.
- Accepts read/write/flush requests from an initiator (cache tester or cache controller), models access latency with `mem_stall`, and returns line data.
- Holds a synthesizable line-wide backing store, applies write granularity per `w_type`, and keeps request statistics.
- Used as the far-end model in cache testbenches and as the FPGA stand-in for main memory.

Parameters:
- IDX_W, 8, log2 of backing-store depth in 128-bit lines (DEPTH = 2^IDX_W).
- LAT, 2, stall cycles per read/write request (0 = never stall, single-cycle completion).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- r  in  1  read request; held by initiator until completion
- w  in  1  write request; held by initiator until completion
- addr  in  36  byte address; line index = addr[4 +: IDX_W]; higher bits ignored (alias)
- wr_data  in  128  write data, lane-aligned to the line
- w_type  in  2  write granularity: 00 word32, 01 line, 10 dword64, 11 line
- flushtype  in  2  11 = clear request; other codes ignored
- mem_stall  out  1  high = request not complete, initiator must hold
- rd_data  out  128  line at current index (combinational read of store)
- rd_count  out  32  completed reads
- wr_count  out  32  completed writes
- err  out  1  sticky protocol error (r and w both high in IDLE)

Behaviour:
- Reset values: FSM = IDLE, `mem_stall` = 0, `rd_count` = `wr_count` = 0, `err` = 0, flush-detect register = 0. Store contents are not touched by reset.
- IDLE, request present (r|w), LAT>0:
  - `mem_stall` = 1 combinationally in the same cycle.
  - Load wait counter with LAT-1 and go to WAIT.
- IDLE, request present, LAT=0:
  - `mem_stall` = 0; the request completes this cycle.
- WAIT:
  - While counter != 0: `mem_stall` = 1, decrement.
  - At counter == 0: `mem_stall` = 0 and the request completes; return to IDLE.
- Timing: a request first seen at cycle t stalls cycles t..t+LAT-1 and completes at cycle t+LAT.
- Completion cycle:
  - Write commits to the store at the clock edge ending that cycle; `wr_count`+1.
  - Read: `rd_data` is valid in that cycle; `rd_count`+1.
- Back-to-back: after a completion, a request still present the next cycle is a new request and stalls again (LAT>0).
- r&w both high when accepted in IDLE:
  - `err` set (sticky until rst).
  - Treated as a write; counts `wr_count` only.
- Write merge:
  - 00: 32-bit lane `addr[3:2]` replaced by the same lane of `wr_data`.
  - 10: 64-bit half `addr[3]` replaced.
  - 01/11: full line replaced.
  - Unwritten lanes are unchanged.
- Flush:
  - Trigger = `flushtype==11` this cycle AND flush-detect register (previous-cycle `flushtype==11`) == 0, evaluated in IDLE.
  - Flush has priority over r/w in the same cycle.
  - Go to FLUSH with `mem_stall` = 1 in the trigger cycle.
  - FLUSH sweeps index 0..DEPTH-1, writing zero to one line per cycle, `mem_stall` = 1 throughout.
  - After the line DEPTH-1 write, return to IDLE; `mem_stall` follows the IDLE rules.
  - Total stall = 1 + DEPTH cycles.
  - A held `flushtype==11` does not retrigger; it must drop for at least one cycle.
- Request changes mid-WAIT are illegal. The responder uses the addr/data/w_type present in the completion cycle.
- Counters wrap at 2^32 silently.
- `rst` mid-WAIT or mid-FLUSH: IDLE next cycle, `mem_stall` = 0, pending write discarded, partially cleared store remains as-is.

Decomposition:
- Package `cache_mem_pkg`:
  - LINE_W=128, ADDR_W=36.
  - `w_type` enum: WT_WORD, WT_LINE, WT_DWORD, WT_LINE2.
  - FLUSH_CLEAR=2'b11.
  - FSM state enum: IDLE, WAIT, FLUSH.
- One sub-module `cache_resp_merge`: combinational old-line/`wr_data`/`w_type`/`addr[3:2]` -> merged line. Unit-testable on its own.

Test Plan:
- Reset, pulse `flushtype=11` 1 cycle, IDX_W=8 -> `mem_stall` high exactly 257 cycles; afterwards read addr 0x0_0000_0A30 gives 0.
- LAT=2, write line `wr_data`=0x0123..EF (`w_type`=01) at addr 0x20 -> stall 2 cycles, completes cycle 3, `wr_count`=1; read 0x20 completes cycle 3 with same data, `rd_count`=1.
- Word write 0xDEADBEEF, `w_type`=00, addr 0x28 over a zeroed line -> line reads 0x00000000_DEADBEEF_00000000_00000000.
- Dword write, `w_type`=10, addr 0x38 -> only bits [127:64] change; addr 0x1000_0030 aliases line 3 with IDX_W=8.
- LAT=0, initiator driving 16384 alternating r/w requests -> `mem_stall` never asserts; final `rd_count`=`wr_count`=8192.
- r=w=1 -> `err`=1 and stays 1; `wr_count`+1 only. Separately, assert rst in the 2nd cycle of FLUSH -> `mem_stall`=0 next cycle, `err`=0, lines 1..255 retain prior data.
